// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: pedestrian request
// states, default timing constants and the light-state encoding used by the
// traffic-light FSM.
package traffic_pkg;

  // Pedestrian request controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    WALK    = 2'b10,
    COOL    = 2'b11
  } ped_state_t;

  // Light-state encoding shared with the traffic-light FSM.
  typedef enum logic [1:0] {
    Green  = 2'b00,
    Yellow = 2'b01,
    Red    = 2'b10
  } light_state_t;

  // Default timing, in ms_tick samples and sec_tick seconds.
  localparam int unsigned DEF_DB_TICKS = 20;
  localparam int unsigned DEF_WALK_S   = 10;
  localparam int unsigned DEF_COOL_S   = 15;
  localparam int unsigned DEF_CNT_W    = 6;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser, level debounce sampled on
// ms_tick, and a one-clk press pulse on each accepted 0->1 transition.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DB_TICKS = DEF_DB_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DB_TICKS);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_TICKS - 1);

  logic            sync_q1;
  logic            btn_s;
  logic            btn_db;
  logic [CntW-1:0] db_cnt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      btn_s   <= sync_q1;
    end
  end

  // Accept a new level only after DB_TICKS consecutive differing samples;
  // press fires in the same clk the debounced level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (ms_tick) begin
        if (btn_s != btn_db) begin
          if (db_cnt == CntLast) begin
            btn_db <= btn_s;
            db_cnt <= '0;
            press  <= btn_s;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian-crossing request front end. Debounces the push-button, raises
// ped_req towards the light controller, times the walk phase and a cooldown,
// and drives the WAIT/WALK indicators.
// Build option: define PED_WAIT_BLINK_EN to blink wait_led at 0.5 Hz while a
// request is pending; otherwise wait_led is steady while pending.
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned DB_TICKS = DEF_DB_TICKS,
  parameter int unsigned WALK_S   = DEF_WALK_S,
  parameter int unsigned COOL_S   = DEF_COOL_S,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_tick,
  input  logic             sec_tick,
  input  logic             btn_raw,
  input  logic             ped_ack,
  output logic             ped_req,
  output logic             walk_led,
  output logic             wait_led,
  output logic [CNT_W-1:0] walk_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] WalkLoad = CNT_W'(WALK_S);
  localparam logic [CNT_W-1:0] CoolLoad = CNT_W'(COOL_S);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  ped_state_t       state;
  logic [CNT_W-1:0] sec_cnt;
  logic             press;

  btn_debounce #(
    .DB_TICKS (DB_TICKS)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .btn_raw (btn_raw),
    .press   (press)
  );

  // Request FSM with registered outputs; each output is written on the edge
  // that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sec_cnt  <= '0;
      ped_req  <= 1'b0;
      walk_led <= 1'b0;
      wait_led <= 1'b0;
      walk_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A press beats a stray ack arriving in the same clk.
          if (press) begin
            state    <= PENDING;
            ped_req  <= 1'b1;
            wait_led <= 1'b1;
            busy     <= 1'b1;
          end
        end

        PENDING: begin
          if (ped_ack) begin
            state    <= WALK;
            sec_cnt  <= WalkLoad;
            walk_cnt <= WalkLoad;
            ped_req  <= 1'b0;
            wait_led <= 1'b0;
            walk_led <= 1'b1;
          end
`ifdef PED_WAIT_BLINK_EN
          else if (sec_tick) begin
            wait_led <= ~wait_led;
          end
`endif
        end

        WALK: begin
          if (sec_tick) begin
            // <= 1 also covers a zero-length walk, so the count never wraps.
            if (sec_cnt <= CntOne) begin
              state    <= COOL;
              sec_cnt  <= CoolLoad;
              walk_led <= 1'b0;
              walk_cnt <= '0;
            end else begin
              sec_cnt  <= sec_cnt - CntOne;
              walk_cnt <= sec_cnt - CntOne;
            end
          end
        end

        COOL: begin
          // A zero-length cooldown leaves on the next clk without a tick.
          if (sec_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sec_tick) begin
            if (sec_cnt == CntOne) begin
              state   <= IDLE;
              sec_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              sec_cnt <= sec_cnt - CntOne;
            end
          end
        end

        default: begin
          state    <= IDLE;
          sec_cnt  <= '0;
          ped_req  <= 1'b0;
          walk_led <= 1'b0;
          wait_led <= 1'b0;
          walk_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Self-checking bench for ped_request_ctrl: directed scenarios plus random
// button/tick/ack traffic, all compared every clk against a behavioural model.
module tb_ped_request_ctrl;

  localparam int DB = 20;
  localparam int WS = 10;
  localparam int CS = 15;
  localparam int CW = 6;
`ifdef PED_WAIT_BLINK_EN
  localparam bit Blink = 1'b1;
`else
  localparam bit Blink = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ms_tick;
  logic          sec_tick;
  logic          btn_raw;
  logic          ped_ack;
  logic          ped_req;
  logic          walk_led;
  logic          wait_led;
  logic [CW-1:0] walk_cnt;
  logic          busy;

  ped_request_ctrl #(
    .DB_TICKS (DB),
    .WALK_S   (WS),
    .COOL_S   (CS),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ms_tick  (ms_tick),
    .sec_tick (sec_tick),
    .btn_raw  (btn_raw),
    .ped_ack  (ped_ack),
    .ped_req  (ped_req),
    .walk_led (walk_led),
    .wait_led (wait_led),
    .walk_cnt (walk_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: what the pedestrian sees, in plain terms.
  // Phase 0 = idle, 1 = waiting for traffic to stop, 2 = walking, 3 = cooldown.
  int m_s1, m_s2;     // button as seen after 1 and 2 clk of synchronisation
  int m_level;        // accepted (debounced) button level
  int m_run;          // consecutive ms samples disagreeing with m_level
  int m_press;        // a press was recognised on the previous edge
  int m_phase;
  int m_rem;          // seconds left in the walk or cooldown
  int m_blink;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_press = 0;
    m_phase = 0; m_rem = 0; m_blink = 0;
  endtask

  task automatic model_step(input int raw, input int ms, input int sec, input int ack);
    int seen_press;
    int new_press;
    seen_press = m_press;
    new_press  = 0;
    if (ms != 0) begin
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level   = m_s2;
          m_run     = 0;
          new_press = m_level;
        end
      end else begin
        m_run = 0;
      end
    end
    m_s2    = m_s1;
    m_s1    = raw;
    m_press = new_press;

    if (m_phase == 0) begin
      if (seen_press != 0) begin
        m_phase = 1;
        m_blink = 1;
      end
    end else if (m_phase == 1) begin
      if (ack != 0) begin
        m_phase = 2;
        m_rem   = WS;
      end else if (sec != 0) begin
        m_blink = 1 - m_blink;
      end
    end else if (m_phase == 2) begin
      if (sec != 0) begin
        if (m_rem <= 1) begin
          m_phase = 3;
          m_rem   = CS;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end else begin
      if (m_rem == 0) begin
        m_phase = 0;
      end else if (sec != 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_phase = 0;
      end
    end
  endtask

  task automatic check_outputs();
    int exp_wait;
    exp_wait = (m_phase == 1) ? (Blink ? m_blink : 1) : 0;
    chk("ped_req",  32'(ped_req),  32'(m_phase == 1));
    chk("walk_led", 32'(walk_led), 32'(m_phase == 2));
    chk("wait_led", 32'(wait_led), 32'(exp_wait));
    chk("walk_cnt", 32'(walk_cnt), 32'((m_phase == 2) ? m_rem : 0));
    chk("busy",     32'(busy),     32'(m_phase != 0));
    if (ped_req && !prev_req) req_rises++;
    prev_req = ped_req;
  endtask

  // One clk: drive inputs at the falling edge, step the model at the rising
  // edge, compare just after it.
  task automatic cycle(input logic raw, input logic ack, input logic sec);
    logic ms;
    @(negedge clk);
    ms       = (cyc % 2 == 0);
    cyc++;
    btn_raw  = raw;
    ped_ack  = ack;
    sec_tick = sec;
    ms_tick  = ms;
    @(posedge clk);
    model_step(int'(raw), int'(ms), int'(sec), int'(ack));
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    btn_raw = 1'b0; ped_ack = 1'b0; ms_tick = 1'b0; sec_tick = 1'b0;
  endtask

  int hold_left;
  logic lvl;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Bounce: toggle every 3 ms for 15 ms, then hold high 25 ms.
    for (int i = 0; i < 30; i++) cycle(((i / 6) % 2) == 0, 1'b0, 1'b0);
    chk("bounce_no_req_yet", 32'(ped_req), 32'd0);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("bounce_pending", 32'(ped_req), 32'd1);
    chk("bounce_one_press", 32'(req_rises), 32'd1);

    // Handshake: long wait with a few second ticks, then a one-clk ack.
    for (int i = 1; i <= 100; i++) cycle(1'b0, 1'b0, (i % 20) == 0);
    chk("wait_req_held", 32'(ped_req), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("ack_req_drop", 32'(ped_req), 32'd0);
    chk("ack_walk_led", 32'(walk_led), 32'd1);
    chk("ack_walk_cnt", 32'(walk_cnt), 32'(WS));

    // Three seconds into the walk, then asynchronous reset.
    for (int t = 0; t < 3; t++) begin
      repeat (4) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
    end
    chk("walk_cnt_7", 32'(walk_cnt), 32'd7);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ped_req",  32'(ped_req),  32'd0);
    chk("rst_walk_led", 32'(walk_led), 32'd0);
    chk("rst_walk_cnt", 32'(walk_cnt), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full walk and cooldown, with presses landing in WALK and in COOL.
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 25; t++) begin
      lvl = (t <= 10) || (t > 15 && t <= 20);
      repeat (19) cycle(lvl, 1'b0, 1'b0);
      cycle(lvl, 1'b0, 1'b1);
      if (t == 9)  chk("walk_cnt_last", 32'(walk_cnt), 32'd1);
      if (t == 10) chk("walk_end_led", 32'(walk_led), 32'd0);
      if (t == 10) chk("cool_busy", 32'(busy), 32'd1);
      if (t == 24) chk("cool_busy_late", 32'(busy), 32'd1);
      if (t == 25) chk("cool_done_busy", 32'(busy), 32'd0);
      if (t == 25) chk("no_queued_press", 32'(ped_req), 32'd0);
    end
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("press_after_idle", 32'(ped_req), 32'd1);

    // Random traffic, including acks outside PENDING and ack/press collisions.
    hold_left = 0;
    lvl = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (hold_left == 0) begin
        lvl       = 1'($urandom_range(0, 1));
        hold_left = int'($urandom_range(1, 80));
      end
      hold_left--;
      cycle(lvl, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
